// File: rtl/sync_key_pkg.sv
// Shared sizing defaults and key-code type for the sync_key keypad front end.
package sync_key_pkg;

   localparam int unsigned N_KEYS_DEFAULT = 20;
   localparam int unsigned CODE_W_DEFAULT = 5;

   typedef logic [CODE_W_DEFAULT-1:0] key_code_t;

endpackage : sync_key_pkg

// File: rtl/sync_key_prio_enc.sv
// Combinational lowest-index priority encoder over the synchronized key lines.
module sync_key_prio_enc
   import sync_key_pkg::*;
#(
   parameter int unsigned N_KEYS = N_KEYS_DEFAULT,
   parameter int unsigned CODE_W = CODE_W_DEFAULT
) (
   input  logic [N_KEYS-1:0] req,
   output logic [CODE_W-1:0] code_c,
   output logic              valid_c
);

   // First set bit from index 0 upward wins; later hits are ignored.
   always_comb begin
      code_c  = '0;
      valid_c = 1'b0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
         if (req[i] && !valid_c) begin
            code_c  = CODE_W'(i);
            valid_c = 1'b1;
         end
      end
   end

endmodule : sync_key_prio_enc

// File: rtl/sync_key.sv
// Two-flop key front end: raw lines are captured, then encoded straight into
// the output register; the last code is kept while no key is pressed.
module sync_key
   import sync_key_pkg::*;
#(
   parameter int unsigned N_KEYS = N_KEYS_DEFAULT,
   parameter int unsigned CODE_W = CODE_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] in,
   output logic              strobe,
   output logic [CODE_W-1:0] out
);

   logic [N_KEYS-1:0] sync_q;
   logic [CODE_W-1:0] enc_code_c;
   logic              enc_valid_c;
   logic [CODE_W-1:0] out_d_c;

   // First stage: raw capture with nothing in front of the flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= in;
      end
   end

   sync_key_prio_enc #(
      .N_KEYS (N_KEYS),
      .CODE_W (CODE_W)
   ) u_prio_enc (
      .req     (sync_q),
      .code_c  (enc_code_c),
      .valid_c (enc_valid_c)
   );

   assign out_d_c = enc_valid_c ? enc_code_c : out;

   // Second stage doubles as the output register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out    <= '0;
         strobe <= 1'b0;
      end else begin
         out    <= out_d_c;
         strobe <= enc_valid_c;
      end
   end

endmodule : sync_key

// File: tb/tb_sync_key.sv
// Randomized self-checking bench for sync_key against a two-sample reference model.
module tb_sync_key;
   import sync_key_pkg::*;

   localparam int unsigned NK = N_KEYS_DEFAULT;
   localparam int unsigned CW = CODE_W_DEFAULT;

   logic          clk;
   logic          rst;
   logic [NK-1:0] key_in;
   logic          strobe;
   key_code_t     out;

   int pass_cnt;
   int total_cnt;

   // Reference state: last value sampled from the pins, and the visible outputs.
   logic [NK-1:0] m_sampled;
   int unsigned   m_out;
   logic          m_strobe;

   sync_key #(
      .N_KEYS (NK),
      .CODE_W (CW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .in     (key_in),
      .strobe (strobe),
      .out    (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Index of the lowest set bit: isolate it, then take its log2.
   function automatic int unsigned lowest_index(input logic [NK-1:0] v);
      logic [NK-1:0] iso;
      iso = v & (~v + NK'(1));
      return $clog2(iso);
   endfunction

   task automatic model_reset();
      m_sampled = '0;
      m_out     = 0;
      m_strobe  = 1'b0;
   endtask

   // One clock: outputs react to what was sampled on the previous edge.
   task automatic model_edge();
      if (m_sampled != '0) begin
         m_out    = lowest_index(m_sampled);
         m_strobe = 1'b1;
      end else begin
         m_strobe = 1'b0;
      end
      m_sampled = key_in;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         check("out", 32'(out), m_out);
         check("strobe", 32'(strobe), 32'(m_strobe));
         check("range", 32'(out < CW'(NK)), 32'd1);
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst       = 1'b0;
      key_in    = '0;
      model_reset();

      // Power-on
      #12;
      check("por_out", 32'(out), 32'd0);
      check("por_strobe", 32'(strobe), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step(2);
      check("idle_out", 32'(out), 32'd0);
      check("idle_strobe", 32'(strobe), 32'd0);
      step(20);
      check("idle_hold_out", 32'(out), 32'd0);
      check("idle_hold_strobe", 32'(strobe), 32'd0);

      // Walk one key across every line
      for (int k = 0; k < int'(NK); k++) begin
         key_in = NK'(1) << k;
         step(2);
         check("walk_out", 32'(out), 32'(k));
         check("walk_strobe", 32'(strobe), 32'd1);
      end

      // Priority then hold-on-idle
      key_in = 20'h00014;
      step(2);
      check("prio_out", 32'(out), 32'd2);
      check("prio_strobe", 32'(strobe), 32'd1);
      key_in = '0;
      step(2);
      check("hold_out", 32'(out), 32'd2);
      check("hold_strobe", 32'(strobe), 32'd0);

      // Reset while a key is held
      key_in = NK'(1) << 3;
      step(2);
      check("pre_rst_out", 32'(out), 32'd3);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("mid_rst_out", 32'(out), 32'd0);
      check("mid_rst_strobe", 32'(strobe), 32'd0);
      @(negedge clk);
      check("in_rst_out", 32'(out), 32'd0);
      rst = 1'b1;
      step(2);
      check("post_rst_out", 32'(out), 32'd3);
      check("post_rst_strobe", 32'(strobe), 32'd1);

      // Latency of a direct key change
      key_in = NK'(1) << 5;
      step(2);
      key_in = NK'(1) << 9;
      step(1);
      check("lat1_out", 32'(out), 32'd5);
      check("lat1_strobe", 32'(strobe), 32'd1);
      step(1);
      check("lat2_out", 32'(out), 32'd9);
      check("lat2_strobe", 32'(strobe), 32'd1);

      // Top key
      key_in = NK'(1) << (NK - 1);
      step(2);
      check("top_out", 32'(out), 32'(NK - 1));
      check("top_strobe", 32'(strobe), 32'd1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 4))
            0: key_in = '0;
            1: key_in = NK'(1) << $urandom_range(0, NK - 1);
            2: key_in = NK'($urandom);
            3: key_in = NK'($urandom) & NK'($urandom) & NK'($urandom);
            default: key_in = key_in;
         endcase
         step(int'($urandom_range(1, 3)));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Safety net: never let the run hang.
   initial begin
      #200000;
      $display("FAIL timeout: got %0d expected %0d", 0, 1);
      $fatal(1, "timeout");
   end

endmodule : tb_sync_key

// File: doc/sync_key.md
SYNC_KEY -- requirements
Module: sync_key

Interface
REQ-001 Parameter N_KEYS, default 20, number of key input lines.
REQ-002 Parameter CODE_W, default 5, key-code width; SHALL satisfy 2**CODE_W >= N_KEYS.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in  input  N_KEYS  raw asynchronous key lines; bit k high = key k pressed.
REQ-006 strobe  output  1  registered; high while at least one synchronized key is pressed.
REQ-007 out  output  CODE_W  registered binary index of the selected pressed key.

Function
REQ-008 The block SHALL sample in into an N_KEYS-wide first synchronizer register on every rising clk edge.
- No logic SHALL sit between in and this register.
REQ-009 The second stage SHALL be the output register.
- It SHALL load the encoding of the first-stage value on every rising edge.
REQ-010 Latency: a change on in, stable across two rising edges, SHALL be visible on out and strobe after the second edge.
REQ-011 Encoding: when any first-stage bit is set, out SHALL load the lowest set bit index and strobe SHALL load 1.
- Example: in = 1<<k gives out = k.
REQ-012 Multiple simultaneous keys: the lowest index SHALL win.
- Example: in = 0x00014 gives out = 2.
REQ-013 No key pressed: strobe SHALL load 0 and out SHALL hold its previous value.
REQ-014 Key 0 pressed alone: out = 0 and strobe = 1; strobe alone distinguishes this from idle.
REQ-015 Index range is 0..N_KEYS-1 (0..19 by default).
- out SHALL never carry a value >= N_KEYS.
REQ-016 Key change between presses (k to j with no idle gap): out SHALL move directly to j with strobe held high.
REQ-017 The block SHALL perform no debounce, edge detection or pulse shaping; strobe is a level.

Reset
REQ-018 While rst is low, the first-stage register, out and strobe SHALL clear to 0 immediately, without waiting for clk.
REQ-019 Deassertion of rst SHALL be synchronous to clk.
- The first rising edge after rst goes high SHALL resume normal sampling.
REQ-020 Reset mid-operation (key held): outputs SHALL clear to 0 during reset.
- After release, outputs SHALL reflect the still-held key within two edges.
REQ-021 Power-on: with in = 0 after reset, out = 0 and strobe = 0 SHALL hold indefinitely.

Structure
REQ-022 Package sync_key_pkg SHALL hold N_KEYS_DEFAULT (20), CODE_W_DEFAULT (5) and the key-code typedef (logic [CODE_W-1:0]).
REQ-023 One sub-module is natural: sync_key_prio_enc.
- Purely combinational, N_KEYS-in lowest-index priority encoder.
- Outputs: code and valid.
REQ-024 The top level SHALL contain only the two register stages and the hold-on-idle mux.

Verification
REQ-025 Power-on: rst low then high, in = 0, wait 2 edges -> out = 0, strobe = 0.
REQ-026 Walk: for k = 0..15 (then 16..19) drive in = 1<<k, wait 2 edges -> out = k, strobe = 1.
REQ-027 Priority and hold: in = 0x00014 -> out = 2, strobe = 1; then in = 0, wait 2 edges -> out = 2, strobe = 0.
REQ-028 Mid-operation reset: in = 1<<3, outputs settle; pull rst low between edges.
- Outputs SHALL read 0 before the next edge.
- Release reset; after 2 edges -> out = 3, strobe = 1.
REQ-029 Latency: change in = 1<<5 to 1<<9 just after an edge.
- After 1 edge: out still 5.
- After 2 edges: out = 9.
REQ-030 Top key: in = 1<<19 -> out = 19, strobe = 1; no out value above 19 at any time in any scenario.
